plot_sink: RTL

Receiving end of the drawers' plot port. Accepts one pixel write per cycle (`vga_plot`/`vga_x`/`vga_y` plus colour) from the ball/paddle drawers and stores it in an on-chip 160×120 framebuffer. Exposes a registered read port for the scan-out logic. Owns the whole-screen clear sequence and applies back-pressure to the drawers while a clear runs.

---
 rtl/pong_pkg.sv | 14 +
 rtl/fb_ram.sv | 19 +
 rtl/plot_sink.sv | 80 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, sink FSM states and the framebuffer address helper.
package pong_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_ADDR_BITS = 15;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} sink_state_t;
  // y*160 + x as two shifts and an add
  function automatic logic [FB_ADDR_BITS-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_BITS-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: single-clock simple dual-port framebuffer RAM, registered read-first read port.
module fb_ram #(
  parameter int W = 3,
  parameter int DEPTH = 19200,
  parameter int ADDR_BITS = 15
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [W-1:0]         rdata_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/plot_sink.sv
// plot_sink: accepts drawer pixel writes into the framebuffer, runs the full-screen clear
// and provides the registered scan-out read port.
module plot_sink import pong_pkg::*; #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int COLOUR_BITS = 3,
  parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vga_plot,
  input  logic [7:0]             vga_x,
  input  logic [6:0]             vga_y,
  input  logic [COLOUR_BITS-1:0] vga_colour,
  output logic                   plot_ready,
  input  logic                   clear_req,
  output logic                   clear_done,
  output logic                   busy,
  input  logic [7:0]             scan_x,
  input  logic [6:0]             scan_y,
  output logic [COLOUR_BITS-1:0] scan_colour,
  output logic [7:0]             oob_count
);
  localparam logic [7:0] W_LIM = 8'(WIDTH);
  localparam logic [6:0] H_LIM = 7'(HEIGHT);
  localparam logic [FB_ADDR_BITS-1:0] LAST = FB_ADDR_BITS'(FB_DEPTH - 1);
  sink_state_t state_q, state_d;
  logic [FB_ADDR_BITS-1:0] clr_q, clr_d, waddr;
  logic [7:0] oob_q, oob_d;
  logic rd_oob_q, plot_oob, accept, we;
  logic [COLOUR_BITS-1:0] wdata, rdata;
  assign plot_ready = state_q == IDLE;
  assign busy = state_q == CLEAR;
  assign clear_done = state_q == DONE;
  assign plot_oob = vga_x >= W_LIM || vga_y >= H_LIM;
  assign accept = vga_plot && plot_ready;
  // the reset edge must not land a clear write, so an aborted clear stops cleanly
  assign we = !reset && (busy || (accept && !plot_oob));
  assign waddr = busy ? clr_q : fb_addr(vga_x, vga_y);
  assign wdata = busy ? CLEAR_COLOUR : vga_colour;
  assign scan_colour = rd_oob_q ? CLEAR_COLOUR : rdata;
  assign oob_count = oob_q;
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    oob_d = (accept && plot_oob && oob_q != 8'hff) ? oob_q + 8'd1 : oob_q;
    case (state_q)
      IDLE: if (clear_req) begin
        state_d = CLEAR;
        clr_d = '0;
      end
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        state_d = clr_q == LAST ? DONE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q <= '0;
      oob_q <= '0;
      rd_oob_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      oob_q <= oob_d;
      rd_oob_q <= scan_x >= W_LIM || scan_y >= H_LIM;
    end
  end
  fb_ram #(.W(COLOUR_BITS), .DEPTH(FB_DEPTH), .ADDR_BITS(FB_ADDR_BITS)) u_ram (
    .clk(clock),
    .we_i(we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(fb_addr(scan_x, scan_y)),
    .rdata_o(rdata)
  );
endmodule
